// File: rtl/fb_render_sched.sv
// Framebuffer write sequencer for pong: clears the screen after reset, then erases/redraws paddles and ball.
// Optional dashed centre net is enabled with `define CENTER_NET_EN.
module fb_render_sched #(
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 120,
   parameter int AW         = 15,
   parameter int DW         = 3,
   parameter int PADDLE_W   = 2,
   parameter int PADDLE_H   = 16,
   parameter int BALL_SIZE  = 4,
   parameter int PADDLE_A_X = 4,
   parameter int PADDLE_B_X = 154,
   parameter logic [DW-1:0] BG_COLOR = 3'b000,
   parameter logic [DW-1:0] FG_COLOR = 3'b111
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          upd_req,
   input  logic [6:0]    paddle_a_y,
   input  logic [6:0]    paddle_b_y,
   input  logic [7:0]    ball_x,
   input  logic [6:0]    ball_y,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_px_addr,
   output logic [DW-1:0] mem_px_data,
   output logic          px_wr
);

   localparam logic [6:0]    PAD_Y_MAX  = 7'(SCREEN_H - PADDLE_H);
   localparam logic [7:0]    BALL_X_MAX = 8'(SCREEN_W - BALL_SIZE);
   localparam logic [6:0]    BALL_Y_MAX = 7'(SCREEN_H - BALL_SIZE);
   localparam logic [7:0]    X_LAST     = 8'(SCREEN_W - 1);
   localparam logic [6:0]    Y_LAST     = 7'(SCREEN_H - 1);
   localparam logic [7:0]    PA_X0      = 8'(PADDLE_A_X);
   localparam logic [7:0]    PA_X1      = 8'(PADDLE_A_X + PADDLE_W - 1);
   localparam logic [7:0]    PB_X0      = 8'(PADDLE_B_X);
   localparam logic [7:0]    PB_X1      = 8'(PADDLE_B_X + PADDLE_W - 1);
   localparam logic [6:0]    PAD_DY     = 7'(PADDLE_H - 1);
   localparam logic [7:0]    BALL_DX    = 8'(BALL_SIZE - 1);
   localparam logic [6:0]    BALL_DY    = 7'(BALL_SIZE - 1);
   localparam logic [AW-1:0] ROW_STEP   = AW'(SCREEN_W);
`ifdef CENTER_NET_EN
   localparam logic [7:0]    NET_X      = 8'(SCREEN_W / 2);
   localparam logic [DW-1:0] NET_COLOR  = DW'(3'b010);
`endif

   typedef enum logic [3:0] {
      ST_CLEAR      = 4'd0,
      ST_IDLE       = 4'd1,
      ST_LATCH      = 4'd2,
      ST_ERASE_A    = 4'd3,
      ST_ERASE_B    = 4'd4,
      ST_ERASE_BALL = 4'd5,
      ST_DRAW_A     = 4'd6,
      ST_DRAW_B     = 4'd7,
      ST_DRAW_BALL  = 4'd8,
      ST_DONE       = 4'd9
   } state_t;

   // Phase activity bits: [0] erase A .. [2] erase ball, [3] draw A .. [5] draw ball.
   function automatic state_t pick_phase(input logic [5:0] act);
      state_t s;
      if (act[0])      s = ST_ERASE_A;
      else if (act[1]) s = ST_ERASE_B;
      else if (act[2]) s = ST_ERASE_BALL;
      else if (act[3]) s = ST_DRAW_A;
      else if (act[4]) s = ST_DRAW_B;
      else if (act[5]) s = ST_DRAW_BALL;
      else             s = ST_DONE;
      return s;
   endfunction

   function automatic logic [5:0] later_mask(input state_t s);
      logic [5:0] m;
      case (s)
         ST_ERASE_A:    m = 6'b111110;
         ST_ERASE_B:    m = 6'b111100;
         ST_ERASE_BALL: m = 6'b111000;
         ST_DRAW_A:     m = 6'b110000;
         ST_DRAW_B:     m = 6'b100000;
         default:       m = 6'b000000;
      endcase
      return m;
   endfunction

   state_t        state_r, state_nxt;
   logic          setup_r, setup_nxt;
   logic [7:0]    cur_x_r, cur_x_nxt;
   logic [6:0]    cur_y_r, cur_y_nxt;
   logic [AW-1:0] row_base_r, row_base_nxt;
   logic [AW-1:0] addr_r, addr_nxt;
   logic [DW-1:0] data_r, data_nxt;
   logic          px_wr_r, px_wr_nxt;
   logic          busy_r, busy_nxt;
   logic          done_r, done_nxt;

   logic          prev_valid_r, in_render_r;
   logic [6:0]    old_a_y_r, old_b_y_r, old_by_r, new_a_y_r, new_b_y_r, new_by_r;
   logic [7:0]    old_bx_r, new_bx_r;
   logic          chg_a_r, chg_b_r, chg_ball_r;

   logic [6:0]    a_y_cl_s, b_y_cl_s, by_cl_s;
   logic [7:0]    bx_cl_s;
   logic          chg_a_s, chg_b_s, chg_ball_s;
   logic [5:0]    act_latch_s, act_r_s;
   logic [7:0]    x_lo_s, x_hi_s;
   logic [6:0]    y_lo_s, y_hi_s;
   logic          erase_s, rect_s, last_s;

   assign a_y_cl_s   = (paddle_a_y > PAD_Y_MAX)  ? PAD_Y_MAX  : paddle_a_y;
   assign b_y_cl_s   = (paddle_b_y > PAD_Y_MAX)  ? PAD_Y_MAX  : paddle_b_y;
   assign bx_cl_s    = (ball_x     > BALL_X_MAX) ? BALL_X_MAX : ball_x;
   assign by_cl_s    = (ball_y     > BALL_Y_MAX) ? BALL_Y_MAX : ball_y;
   assign chg_a_s    = !prev_valid_r || (a_y_cl_s != old_a_y_r);
   assign chg_b_s    = !prev_valid_r || (b_y_cl_s != old_b_y_r);
   assign chg_ball_s = !prev_valid_r || (bx_cl_s != old_bx_r) || (by_cl_s != old_by_r);
   // Erases only make sense once a previous frame has actually been drawn.
   assign act_latch_s = {chg_ball_s, chg_b_s, chg_a_s,
                         chg_ball_s & prev_valid_r, chg_b_s & prev_valid_r, chg_a_s & prev_valid_r};
   assign act_r_s     = {chg_ball_r, chg_b_r, chg_a_r,
                         chg_ball_r & prev_valid_r, chg_b_r & prev_valid_r, chg_a_r & prev_valid_r};

   // Rectangle bounds and colour class of the phase being executed.
   always_comb begin
      x_lo_s  = 8'd0;
      x_hi_s  = X_LAST;
      y_lo_s  = 7'd0;
      y_hi_s  = Y_LAST;
      erase_s = 1'b1;
      rect_s  = 1'b1;
      case (state_r)
         ST_CLEAR:      rect_s = 1'b1;
         ST_ERASE_A:    begin x_lo_s = PA_X0; x_hi_s = PA_X1; y_lo_s = old_a_y_r; y_hi_s = old_a_y_r + PAD_DY; end
         ST_ERASE_B:    begin x_lo_s = PB_X0; x_hi_s = PB_X1; y_lo_s = old_b_y_r; y_hi_s = old_b_y_r + PAD_DY; end
         ST_ERASE_BALL: begin x_lo_s = old_bx_r; x_hi_s = old_bx_r + BALL_DX; y_lo_s = old_by_r; y_hi_s = old_by_r + BALL_DY; end
         ST_DRAW_A:     begin x_lo_s = PA_X0; x_hi_s = PA_X1; y_lo_s = new_a_y_r; y_hi_s = new_a_y_r + PAD_DY; erase_s = 1'b0; end
         ST_DRAW_B:     begin x_lo_s = PB_X0; x_hi_s = PB_X1; y_lo_s = new_b_y_r; y_hi_s = new_b_y_r + PAD_DY; erase_s = 1'b0; end
         ST_DRAW_BALL:  begin x_lo_s = new_bx_r; x_hi_s = new_bx_r + BALL_DX; y_lo_s = new_by_r; y_hi_s = new_by_r + BALL_DY; erase_s = 1'b0; end
         default:       rect_s = 1'b0;
      endcase
   end

   assign last_s = (cur_x_r == x_hi_s) && (cur_y_r == y_hi_s);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_CLEAR;
      else      state_r <= state_nxt;
   end

   // Next-state logic; a phase ends on its last pixel and hands over to the next active phase.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (!setup_r && last_s) state_nxt = ST_DONE;
            else                    state_nxt = ST_CLEAR;
         end
         ST_IDLE: begin
            if (upd_req) state_nxt = ST_LATCH;
            else         state_nxt = ST_IDLE;
         end
         ST_LATCH: state_nxt = pick_phase(act_latch_s);
         ST_ERASE_A, ST_ERASE_B, ST_ERASE_BALL, ST_DRAW_A, ST_DRAW_B, ST_DRAW_BALL: begin
            if (!setup_r && last_s) state_nxt = pick_phase(act_r_s & later_mask(state_r));
            else                    state_nxt = state_r;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_CLEAR;
      endcase
   end

   // Output logic: next pixel address/data/strobe, walked incrementally through the rectangle.
   always_comb begin
      px_wr_nxt    = 1'b0;
      addr_nxt     = addr_r;
      cur_x_nxt    = cur_x_r;
      cur_y_nxt    = cur_y_r;
      row_base_nxt = row_base_r;
      setup_nxt    = 1'b1;
      busy_nxt     = (state_nxt != ST_IDLE);
      done_nxt     = (state_r == ST_DONE);
      if (rect_s) begin
         if (setup_r) begin
            setup_nxt    = 1'b0;
            px_wr_nxt    = 1'b1;
            cur_x_nxt    = x_lo_s;
            cur_y_nxt    = y_lo_s;
            row_base_nxt = AW'(y_lo_s) * ROW_STEP;
            addr_nxt     = row_base_nxt + AW'(x_lo_s);
         end else if (last_s) begin
            setup_nxt = 1'b1;
         end else if (cur_x_r == x_hi_s) begin
            setup_nxt    = 1'b0;
            px_wr_nxt    = 1'b1;
            cur_x_nxt    = x_lo_s;
            cur_y_nxt    = cur_y_r + 7'd1;
            row_base_nxt = row_base_r + ROW_STEP;
            addr_nxt     = row_base_nxt + AW'(x_lo_s);
         end else begin
            setup_nxt = 1'b0;
            px_wr_nxt = 1'b1;
            cur_x_nxt = cur_x_r + 8'd1;
            addr_nxt  = addr_r + AW'(1'b1);
         end
      end else begin
         setup_nxt = 1'b1;
      end
      if (px_wr_nxt) begin
         if (!erase_s) data_nxt = FG_COLOR;
`ifdef CENTER_NET_EN
         else if ((cur_x_nxt == NET_X) && (cur_y_nxt[2] == 1'b0)) data_nxt = NET_COLOR;
`endif
         else data_nxt = BG_COLOR;
      end else begin
         data_nxt = data_r;
      end
   end

   // Registered outputs and pixel walker.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         px_wr_r    <= 1'b0;
         addr_r     <= '0;
         data_r     <= '0;
         busy_r     <= 1'b1;
         done_r     <= 1'b0;
         setup_r    <= 1'b1;
         cur_x_r    <= 8'd0;
         cur_y_r    <= 7'd0;
         row_base_r <= '0;
      end else begin
         px_wr_r    <= px_wr_nxt;
         addr_r     <= addr_nxt;
         data_r     <= data_nxt;
         busy_r     <= busy_nxt;
         done_r     <= done_nxt;
         setup_r    <= setup_nxt;
         cur_x_r    <= cur_x_nxt;
         cur_y_r    <= cur_y_nxt;
         row_base_r <= row_base_nxt;
      end
   end

   // Position bookkeeping; DONE after the post-reset clear must not validate stale positions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_valid_r <= 1'b0;
         in_render_r  <= 1'b0;
         old_a_y_r    <= 7'd0;
         old_b_y_r    <= 7'd0;
         old_bx_r     <= 8'd0;
         old_by_r     <= 7'd0;
         new_a_y_r    <= 7'd0;
         new_b_y_r    <= 7'd0;
         new_bx_r     <= 8'd0;
         new_by_r     <= 7'd0;
         chg_a_r      <= 1'b0;
         chg_b_r      <= 1'b0;
         chg_ball_r   <= 1'b0;
      end else if (state_r == ST_LATCH) begin
         new_a_y_r   <= a_y_cl_s;
         new_b_y_r   <= b_y_cl_s;
         new_bx_r    <= bx_cl_s;
         new_by_r    <= by_cl_s;
         chg_a_r     <= chg_a_s;
         chg_b_r     <= chg_b_s;
         chg_ball_r  <= chg_ball_s;
         in_render_r <= 1'b1;
      end else if ((state_r == ST_DONE) && in_render_r) begin
         old_a_y_r    <= new_a_y_r;
         old_b_y_r    <= new_b_y_r;
         old_bx_r     <= new_bx_r;
         old_by_r     <= new_by_r;
         prev_valid_r <= 1'b1;
         in_render_r  <= 1'b0;
      end else begin
         in_render_r <= in_render_r;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign mem_px_addr = addr_r;
   assign mem_px_data = data_r;
   assign px_wr       = px_wr_r;

endmodule

// File: tb/tb_fb_render_sched.sv
// Scoreboard bench for fb_render_sched: a rectangle-level model queues expected pixel writes,
// a negedge monitor pops and compares every px_wr cycle.
module tb_fb_render_sched;
   localparam int W = 160;
   localparam int H = 120;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        upd_req = 1'b0;
   logic [6:0]  paddle_a_y = 7'd0, paddle_b_y = 7'd0, ball_y = 7'd0;
   logic [7:0]  ball_x = 8'd0;
   logic        busy, done, px_wr;
   logic [14:0] mem_px_addr;
   logic [2:0]  mem_px_data;

   always #5 clk = ~clk;

   fb_render_sched dut (
      .clk(clk), .rst(rst), .upd_req(upd_req),
      .paddle_a_y(paddle_a_y), .paddle_b_y(paddle_b_y), .ball_x(ball_x), .ball_y(ball_y),
      .busy(busy), .done(done), .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr)
   );

   typedef struct { int addr; int data; } px_t;
   px_t exp_q[$];
   px_t mon_e;
   int  n_cmp = 0, n_err = 0, wr_cnt = 0, done_cnt = 0;
   int  ref_pv = 0, ref_a = 0, ref_b = 0, ref_bx = 0, ref_by = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int erase_color(input int x, input int y);
`ifdef CENTER_NET_EN
      if (x == W / 2 && ((y / 4) % 2) == 0) return 2;
`endif
      return (x < 0 && y < 0) ? 1 : 0;
   endfunction

   task automatic push_rect(input int x0, input int y0, input int w, input int h,
                            input bit erase, inout int nph, inout int nw);
      px_t p;
      nph++;
      for (int y = y0; y < y0 + h; y++)
         for (int x = x0; x < x0 + w; x++) begin
            p.addr = y * W + x;
            p.data = erase ? erase_color(x, y) : 7;
            exp_q.push_back(p);
            nw++;
         end
   endtask

   task automatic model_clear();
      px_t p;
      for (int i = 0; i < W * H; i++) begin
         p.addr = i;
         p.data = erase_color(i % W, i / W);
         exp_q.push_back(p);
      end
      ref_pv = 0;
   endtask

   task automatic model_render(input int a, input int b, input int bx, input int by, output int lat);
      int ca, cb, cx, cy, nph, nw;
      bit ch_a, ch_b, ch_ball;
      ca = (a > H - 16) ? H - 16 : a;
      cb = (b > H - 16) ? H - 16 : b;
      cx = (bx > W - 4) ? W - 4 : bx;
      cy = (by > H - 4) ? H - 4 : by;
      ch_a    = (ref_pv == 0) || (ca != ref_a);
      ch_b    = (ref_pv == 0) || (cb != ref_b);
      ch_ball = (ref_pv == 0) || (cx != ref_bx) || (cy != ref_by);
      nph = 0;
      nw  = 0;
      if (ref_pv != 0 && ch_a)    push_rect(4,      ref_a,  2, 16, 1'b1, nph, nw);
      if (ref_pv != 0 && ch_b)    push_rect(154,    ref_b,  2, 16, 1'b1, nph, nw);
      if (ref_pv != 0 && ch_ball) push_rect(ref_bx, ref_by, 4, 4,  1'b1, nph, nw);
      if (ch_a)    push_rect(4,   ca, 2, 16, 1'b0, nph, nw);
      if (ch_b)    push_rect(154, cb, 2, 16, 1'b0, nph, nw);
      if (ch_ball) push_rect(cx,  cy, 4, 4,  1'b0, nph, nw);
      lat = 1 + nph + nw + 1;
      ref_pv = 1; ref_a = ca; ref_b = cb; ref_bx = cx; ref_by = cy;
   endtask

   // Scoreboard monitor: every write cycle must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst && px_wr) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: addr %0d data %0d with empty scoreboard", mem_px_addr, mem_px_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("px_addr", int'(mem_px_addr), mon_e.addr);
            chk("px_data", int'(mem_px_data), mon_e.data);
         end
      end
      if (rst && done) done_cnt++;
   end

   task automatic wait_done(input string name, input int lat, input int pa, input int pb, input bit scramble);
      int cnt, got;
      cnt = 0;
      got = -1;
      while (cnt < lat + 64) begin
         @(negedge clk);
         cnt++;
         upd_req = (cnt == pa || cnt == pb) ? 1'b1 : 1'b0;
         if (scramble && cnt == 1) begin
            paddle_a_y = paddle_a_y + 7'd9;
            ball_x     = ball_x + 8'd3;
         end
         if (done) begin
            got = cnt;
            break;
         end
      end
      upd_req = 1'b0;
      chk({name, "_done_latency"}, got, lat);
   endtask

   task automatic settle(input string name, input int d0);
      repeat (4) @(negedge clk);
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_done_pulses"}, done_cnt - d0, 1);
      chk({name, "_busy_idle"}, int'(busy), 0);
   endtask

   task automatic do_clear(input string name);
      int d0;
      d0 = done_cnt;
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      chk({name, "_busy"}, int'(busy), 1);
      wait_done(name, W * H + 2, 0, 0, 1'b0);
      settle(name, d0);
   endtask

   task automatic start_render(input int a, input int b, input int bx, input int by, output int lat);
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      paddle_a_y = 7'(a);
      paddle_b_y = 7'(b);
      ball_x     = 8'(bx);
      ball_y     = 7'(by);
      upd_req    = 1'b1;
      @(negedge clk);
      upd_req = 1'b0;
      chk("latch_busy", int'(busy), 1);
      model_render(a, b, bx, by, lat);
   endtask

   task automatic do_render(input string name, input int a, input int b, input int bx, input int by, input bit ign);
      int d0, lat;
      d0 = done_cnt;
      start_render(a, b, bx, by, lat);
      if (ign) wait_done(name, lat, lat / 2, lat - 1, 1'b1);
      else     wait_done(name, lat, 0, 0, 1'b0);
      settle(name, d0);
   endtask

   initial begin
      int base, lat, na;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  int'(busy), 1);
      chk("rst_px_wr", int'(px_wr), 0);
      chk("rst_addr",  int'(mem_px_addr), 0);
      chk("rst_data",  int'(mem_px_data), 0);
      chk("rst_done",  int'(done), 0);
      do_clear("clear0");

      do_render("first",    10, 20, 80, 60, 1'b0);
      do_render("ball_mv",  10, 20, 81, 61, 1'b0);
      do_render("clamp",   127, 20, 200, 61, 1'b0);
      do_render("nochange",127, 20, 200, 61, 1'b0);
      do_render("ignored",  30, 40, 50, 70, 1'b1);

      // Reset in the middle of DRAW_A: paddle A moves, so 32 erase writes precede the draw.
      na = (ref_a + 30) % 100;
      start_render(na, ref_b, ref_bx, ref_by, lat);
      base = wr_cnt;
      for (int i = 0; i < 200 && (wr_cnt - base) < 40; i++) @(negedge clk);
      chk("mid_draw_reached", int'((wr_cnt - base) >= 40), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_px_wr", int'(px_wr), 0);
      chk("async_busy",  int'(busy), 1);
      chk("async_addr",  int'(mem_px_addr), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      do_clear("clear1");
      do_render("post_rst", 55, 66, 77, 88, 1'b0);

      for (int i = 0; i < 16; i++) begin
         int a, b, bx, by;
         a  = ($urandom_range(0, 2) == 0) ? ref_a  : int'($urandom_range(0, 127));
         b  = ($urandom_range(0, 2) == 0) ? ref_b  : int'($urandom_range(0, 127));
         bx = ($urandom_range(0, 2) == 0) ? ref_bx : int'($urandom_range(0, 255));
         by = ($urandom_range(0, 2) == 0) ? ref_by : int'($urandom_range(0, 127));
         do_render("rnd", a, b, bx, by, (i % 4) == 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
